// File: rtl/ppu_cpu_port.sv
// ppu_cpu_port: PPU CPU register window ($2000-$2007), loopy scroll state, $2007 VRAM req/ack, OAM port, NMI.
// Optional open-bus decay of the io latch is enabled by defining OPEN_BUS_DECAY_EN.
module ppu_cpu_port #(
    parameter int VRAM_AW = 14,
    parameter int OAM_AW = 8,
    parameter logic [VRAM_AW-1:0] PAL_BASE = 'h3F00,
    parameter int DECAY_CYCLES = 5000000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CS,
    input  logic               RW,
    input  logic [2:0]         CPU_A,
    input  logic [7:0]         CPU_DI,
    output logic [7:0]         CPU_DO,
    output logic               RD_VALID,
    output logic               BUSY,
    output logic               INT,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               spr0_hit,
    input  logic               spr_ovf,
    input  logic               hcopy,
    input  logic               vcopy,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic [OAM_AW-1:0]  oam_addr,
    output logic               oam_we,
    output logic [7:0]         oam_wdata,
    input  logic [7:0]         oam_rdata,
    output logic [7:0]         ctrl_o,
    output logic [7:0]         mask_o,
    output logic [14:0]        v_o,
    output logic [14:0]        t_o,
    output logic [2:0]         x_o
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state_q, state_d;
    logic [7:0] ctrl_q, ctrl_d, mask_q, mask_d, buf_q, buf_d, io_q, io_d, do_q, do_d, wdata_q, wdata_d, rd_data;
    logic [OAM_AW-1:0] oam_q, oam_d;
    logic [14:0] v_q, v_d, t_q, t_d;
    logic [2:0] x_q, x_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic w_q, w_d, vbl_q, vbl_d, rdv_q, rdv_d, int_q, we_q, we_d, pal_q, pal_d;
    logic wr, rd, busy, pal_now, decay;
    assign wr = CS & ~RW;
    assign rd = CS & RW;
    assign busy = state_q == REQ;
    assign pal_now = v_q[VRAM_AW-1:0] >= PAL_BASE;
    assign rd_data = CPU_A == 3'd2 ? {vbl_q, spr0_hit, spr_ovf, io_q[4:0]} :
                     CPU_A == 3'd4 ? oam_rdata : CPU_A == 3'd7 ? buf_q : io_q;
`ifdef OPEN_BUS_DECAY_EN
    localparam int CW = $clog2(DECAY_CYCLES + 1);
    logic [CW-1:0] dec_q;
    always_ff @(posedge CLK) begin
        if (RST || CS) dec_q <= '0;
        else if (dec_q != CW'(DECAY_CYCLES)) dec_q <= dec_q + 1'b1;
    end
    assign decay = !CS && dec_q == CW'(DECAY_CYCLES - 1);
`else
    assign decay = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        ctrl_d = ctrl_q;
        mask_d = mask_q;
        buf_d = buf_q;
        io_d = decay ? 8'h00 : io_q;
        do_d = do_q;
        wdata_d = wdata_q;
        oam_d = oam_q;
        v_d = v_q;
        t_d = t_q;
        x_d = x_q;
        addr_d = addr_q;
        w_d = w_q;
        we_d = we_q;
        pal_d = pal_q;
        rdv_d = 1'b0;
        vbl_d = vblank_clr ? 1'b0 : vblank_set ? 1'b1 : vbl_q;
        if (busy && vram_ack) v_d = v_q + (ctrl_q[2] ? 15'd32 : 15'd1);
        if (hcopy) {v_d[10], v_d[4:0]} = {t_q[10], t_q[4:0]};
        if (vcopy) {v_d[14:11], v_d[9:5]} = {t_q[14:11], t_q[9:5]};
        if (rd && !(CPU_A == 3'd7 && (busy || pal_now))) begin
            do_d = rd_data;
            rdv_d = 1'b1;
            io_d = rd_data;
        end
        if (wr && !(CPU_A == 3'd7 && busy)) io_d = CPU_DI;
        if (rd && CPU_A == 3'd2) begin
            vbl_d = 1'b0;
            w_d = 1'b0;
        end
        if (wr) begin
            case (CPU_A)
                3'd0: begin
                    ctrl_d = CPU_DI;
                    t_d[11:10] = CPU_DI[1:0];
                end
                3'd1: mask_d = CPU_DI;
                3'd3: oam_d = OAM_AW'(CPU_DI);
                3'd4: oam_d = oam_q + 1'b1;
                3'd5: begin
                    if (!w_q) {t_d[4:0], x_d} = CPU_DI;
                    else {t_d[9:5], t_d[14:12]} = CPU_DI;
                    w_d = ~w_q;
                end
                3'd6: begin
                    if (!w_q) t_d[14:8] = {1'b0, CPU_DI[5:0]};
                    else begin
                        t_d[7:0] = CPU_DI;
                        v_d = {t_q[14:8], CPU_DI};
                    end
                    w_d = ~w_q;
                end
                default: ;
            endcase
        end
        if (!busy && CS && CPU_A == 3'd7) begin
            state_d = REQ;
            we_d = ~RW;
            addr_d = v_q[VRAM_AW-1:0];
            wdata_d = CPU_DI;
            pal_d = RW & pal_now;
        end
        if (busy && vram_ack) begin
            state_d = IDLE;
            buf_d = we_q ? buf_q : vram_rdata;
            // palette reads skip the buffer delay and answer straight from memory
            if (!we_q && pal_q) begin
                do_d = vram_rdata;
                rdv_d = 1'b1;
                io_d = vram_rdata;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            ctrl_q <= '0;
            mask_q <= '0;
            buf_q <= '0;
            io_q <= '0;
            do_q <= '0;
            wdata_q <= '0;
            oam_q <= '0;
            v_q <= '0;
            t_q <= '0;
            x_q <= '0;
            addr_q <= '0;
            w_q <= 1'b0;
            we_q <= 1'b0;
            pal_q <= 1'b0;
            rdv_q <= 1'b0;
            vbl_q <= 1'b0;
            int_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ctrl_q <= ctrl_d;
            mask_q <= mask_d;
            buf_q <= buf_d;
            io_q <= io_d;
            do_q <= do_d;
            wdata_q <= wdata_d;
            oam_q <= oam_d;
            v_q <= v_d;
            t_q <= t_d;
            x_q <= x_d;
            addr_q <= addr_d;
            w_q <= w_d;
            we_q <= we_d;
            pal_q <= pal_d;
            rdv_q <= rdv_d;
            vbl_q <= vbl_d;
            int_q <= ~(ctrl_d[7] & vbl_d);
        end
    end
    assign CPU_DO = do_q;
    assign RD_VALID = rdv_q;
    assign BUSY = busy;
    assign INT = int_q;
    assign vram_req = busy;
    assign vram_we = we_q;
    assign vram_addr = addr_q;
    assign vram_wdata = wdata_q;
    assign oam_addr = oam_q;
    assign oam_we = wr && CPU_A == 3'd4 && !RST;
    assign oam_wdata = CPU_DI;
    assign ctrl_o = ctrl_q;
    assign mask_o = mask_q;
    assign v_o = v_q;
    assign t_o = t_q;
    assign x_o = x_q;
endmodule

// File: tb/tb_ppu_cpu_port.sv
// tb_ppu_cpu_port: directed-vector bench for ppu_cpu_port; inputs driven and outputs sampled on negedge.
module tb_ppu_cpu_port;
    logic CLK = 1'b0, RST = 1'b1, CS = 1'b0, RW = 1'b1;
    logic [2:0] CPU_A = '0;
    logic [7:0] CPU_DI = '0, CPU_DO, vram_wdata, vram_rdata = '0, oam_wdata, oam_rdata = '0, ctrl_o, mask_o;
    logic RD_VALID, BUSY, INT, vram_req, vram_we, oam_we;
    logic vblank_set = 1'b0, vblank_clr = 1'b0, spr0_hit = 1'b0, spr_ovf = 1'b0, hcopy = 1'b0, vcopy = 1'b0, vram_ack = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0] oam_addr;
    logic [14:0] v_o, t_o;
    logic [2:0] x_o;
    int n_chk = 0, n_pass = 0;
    always #5 CLK = ~CLK;
    ppu_cpu_port dut (
        .CLK(CLK), .RST(RST), .CS(CS), .RW(RW), .CPU_A(CPU_A), .CPU_DI(CPU_DI), .CPU_DO(CPU_DO),
        .RD_VALID(RD_VALID), .BUSY(BUSY), .INT(INT), .vblank_set(vblank_set), .vblank_clr(vblank_clr),
        .spr0_hit(spr0_hit), .spr_ovf(spr_ovf), .hcopy(hcopy), .vcopy(vcopy), .vram_req(vram_req),
        .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_ack(vram_ack),
        .vram_rdata(vram_rdata), .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
        .oam_rdata(oam_rdata), .ctrl_o(ctrl_o), .mask_o(mask_o), .v_o(v_o), .t_o(t_o), .x_o(x_o)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask
    task automatic acc(input logic [2:0] a, input logic rw, input logic [7:0] d);
        CS = 1'b1;
        RW = rw;
        CPU_A = a;
        CPU_DI = d;
        @(negedge CLK);
        CS = 1'b0;
        RW = 1'b1;
    endtask
    task automatic ack(input logic [7:0] d);
        int n = 0;
        while (!vram_req && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("ack_wait", vram_req, 1);
        vram_rdata = d;
        vram_ack = 1'b1;
        @(negedge CLK);
        vram_ack = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1);
    end
    initial begin
        @(negedge CLK);
        reset();
        check("rst_do", CPU_DO, 8'h00);
        check("rst_rdv", RD_VALID, 0);
        check("rst_busy", BUSY, 0);
        check("rst_int", INT, 1);
        check("rst_req", vram_req, 0);
        check("rst_v", v_o, 15'h0);
        acc(6, 0, 8'h21);
        acc(6, 0, 8'h08);
        check("v_2006", v_o, 15'h2108);
        acc(7, 0, 8'hAB);
        check("wr_req", vram_req, 1);
        check("wr_we", vram_we, 1);
        check("wr_addr", vram_addr, 14'h2108);
        check("wr_data", vram_wdata, 8'hAB);
        check("wr_busy", BUSY, 1);
        acc(7, 0, 8'hCD);
        check("busy_hold", vram_wdata, 8'hAB);
        ack(8'h00);
        check("wr_vinc", v_o, 15'h2109);
        check("wr_idle", vram_req, 0);
        reset();
        acc(0, 0, 8'h04);
        acc(6, 0, 8'h20);
        acc(6, 0, 8'h00);
        acc(7, 1, 8'h00);
        check("rd1_rdv", RD_VALID, 1);
        check("rd1_do", CPU_DO, 8'h00);
        check("rd1_we", vram_we, 0);
        ack(8'h11);
        acc(7, 1, 8'h00);
        check("rd2_do", CPU_DO, 8'h11);
        ack(8'h22);
        check("rd_v32", v_o, 15'h2040);
        reset();
        acc(6, 0, 8'h3F);
        acc(6, 0, 8'h00);
        acc(7, 1, 8'h00);
        check("pal_nordv", RD_VALID, 0);
        ack(8'h0F);
        check("pal_rdv", RD_VALID, 1);
        check("pal_do", CPU_DO, 8'h0F);
        check("pal_v", v_o, 15'h3F01);
        acc(3, 1, 8'h00);
        check("io_pal", CPU_DO, 8'h0F);
        reset();
        vblank_set = 1'b1;
        @(negedge CLK);
        vblank_set = 1'b0;
        check("int_noen", INT, 1);
        acc(0, 0, 8'h80);
        check("int_on", INT, 0);
        acc(2, 1, 8'h00);
        check("st_vbl", CPU_DO, 8'h80);
        check("int_off", INT, 1);
        acc(2, 1, 8'h00);
        check("st_clr", CPU_DO, 8'h00);
        vblank_set = 1'b1;
        acc(2, 1, 8'h00);
        vblank_set = 1'b0;
        check("st_race", CPU_DO, 8'h00);
        @(negedge CLK);
        check("int_race", INT, 1);
        vblank_set = 1'b1;
        vblank_clr = 1'b1;
        @(negedge CLK);
        vblank_set = 1'b0;
        vblank_clr = 1'b0;
        @(negedge CLK);
        check("int_clrwin", INT, 1);
        spr0_hit = 1'b1;
        acc(2, 1, 8'h00);
        spr0_hit = 1'b0;
        check("st_spr0", CPU_DO, 8'h40);
        reset();
        acc(5, 0, 8'h7D);
        check("x_5", x_o, 3'd5);
        acc(5, 0, 8'h5E);
        check("t_2005", t_o, 15'h616F);
        check("x_keep", x_o, 3'd5);
        acc(5, 0, 8'h7D);
        acc(2, 1, 8'h00);
        acc(5, 0, 8'hE3);
        check("w_reset_x", x_o, 3'd3);
        check("w_reset_t", t_o, 15'h617C);
        hcopy = 1'b1;
        @(negedge CLK);
        hcopy = 1'b0;
        check("hcopy", v_o, 15'h001C);
        vcopy = 1'b1;
        @(negedge CLK);
        vcopy = 1'b0;
        check("vcopy", v_o, 15'h617C);
        acc(1, 0, 8'hA5);
        check("mask", mask_o, 8'hA5);
        acc(3, 1, 8'h00);
        check("io_wo", CPU_DO, 8'hA5);
        acc(3, 0, 8'hFF);
        check("oamaddr", oam_addr, 8'hFF);
        CS = 1'b1;
        RW = 1'b0;
        CPU_A = 3'd4;
        CPU_DI = 8'h12;
        #1;
        check("oam_we", oam_we, 1);
        check("oam_wd", oam_wdata, 8'h12);
        @(negedge CLK);
        CS = 1'b0;
        RW = 1'b1;
        #1;
        check("oam_wrap", oam_addr, 8'h00);
        check("oam_we0", oam_we, 0);
        oam_rdata = 8'h5A;
        acc(4, 1, 8'h00);
        check("oam_rd", CPU_DO, 8'h5A);
        check("oam_noinc", oam_addr, 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
